// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// Parametrised multi-digit up/down BCD counter. DIGITS cascaded decade stages,
// each counting 0..9, with ripple carry/borrow between digits, parallel load,
// per-digit terminal flags and cascade outputs for chaining instances.
//
// Build option:
//   BCD_SATURATE_EN  (undefined by default)
//     undefined : inc at all-9s wraps to all-0s, dec at all-0s wraps to all-9s
//     defined   : inc at all-9s holds all-9s, dec at all-0s holds all-0s;
//                 carry_out / borrow_out still pulse on the blocked step
//
// Parameters:
//   DIGITS      number of BCD digits (1..8); counter width is 4*DIGITS
//
// Ports:
//   clock       system clock, all state on rising edge
//   reset       synchronous, active-high; clears Count to 0
//   inc         count-up enable, one step per cycle while high
//   dec         count-down enable, one step per cycle while high
//   load        parallel load strobe (priority below reset, above inc/dec)
//   load_val    BCD value loaded when load=1; digit 0 in [3:0]; digits > 9
//               are stored as 0
//   Count       registered BCD count; digit 0 in [3:0]
//   digit_eq_9  bit i set when digit i == 9 (decoded from Count)
//   digit_eq_0  bit i set when digit i == 0 (decoded from Count)
//   carry_out   combinational: an up-step from all-9s happens this cycle
//   borrow_out  combinational: a down-step from all-0s happens this cycle
//
// Cascade handshake: carry_out/borrow_out are single-cycle strobes that are
// valid in the same cycle as the causing inc/dec; the downstream instance
// samples them as its inc/dec on the same rising edge the upstream wraps.
// There is no back-pressure.
// -----------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int DIGITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] Count,
    output logic [DIGITS-1:0]   digit_eq_9,
    output logic [DIGITS-1:0]   digit_eq_0,
    output logic                carry_out,
    output logic                borrow_out
);

    localparam int W = 4 * DIGITS;

    // Qualified step requests: reset and load both pre-empt counting.
    logic step_up;
    logic step_dn;
    // Step actually applied to Count (differs only in the saturating build).
    logic apply_up;
    logic apply_dn;

    logic full;
    logic empty;

    // up_en[i]: digits 0..i-1 are all 9, so digit i takes part in an up-step.
    // dn_en[i]: digits 0..i-1 are all 0, so digit i takes part in a down-step.
    logic [DIGITS-1:0] up_en;
    logic [DIGITS-1:0] dn_en;

    logic [W-1:0] load_fix;
    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;

    // -------------------------------------------------------------------------
    // Per-digit terminal decode from the registered count only.
    // -------------------------------------------------------------------------
    always_comb begin : digit_decode
        digit_eq_9 = '0;
        digit_eq_0 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_eq_9[i] = (Count[4*i +: 4] == 4'd9);
            digit_eq_0[i] = (Count[4*i +: 4] == 4'd0);
        end
    end

    assign full  = &digit_eq_9;
    assign empty = &digit_eq_0;

    assign step_up = inc & ~dec & ~load & ~reset;
    assign step_dn = dec & ~inc & ~load & ~reset;

    assign carry_out  = step_up & full;
    assign borrow_out = step_dn & empty;

`ifdef BCD_SATURATE_EN
    // Block the step that would wrap; the cascade strobes above still fire
    // so an upstream overflow attempt remains visible.
    assign apply_up = step_up & ~full;
    assign apply_dn = step_dn & ~empty;
`else
    assign apply_up = step_up;
    assign apply_dn = step_dn;
`endif

    // -------------------------------------------------------------------------
    // Ripple enables. Written as a running AND so the whole chain is a single
    // combinational prefix that closes within one clock.
    // -------------------------------------------------------------------------
    always_comb begin : ripple_enables
        logic run9;
        logic run0;
        run9  = 1'b1;
        run0  = 1'b1;
        up_en = '0;
        dn_en = '0;
        for (int i = 0; i < DIGITS; i++) begin
            up_en[i] = run9;
            dn_en[i] = run0;
            run9     = run9 & digit_eq_9[i];
            run0     = run0 & digit_eq_0[i];
        end
    end

    // -------------------------------------------------------------------------
    // Candidate next values for each operation, computed digit by digit.
    // A digit that steps past 9 (up) or below 0 (down) rolls to 0 / 9; with
    // every digit rolling this produces the default-build wrap-around.
    // -------------------------------------------------------------------------
    always_comb begin : next_values
        logic [3:0] d;
        logic [3:0] lv;
        d        = '0;
        lv       = '0;
        load_fix = '0;
        up_val   = '0;
        dn_val   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d  = Count[4*i +: 4];
            lv = load_val[4*i +: 4];

            // Non-BCD load digits are squashed to 0 so Count stays legal.
            load_fix[4*i +: 4] = (lv > 4'd9) ? 4'd0 : lv;

            if (!up_en[i]) begin
                up_val[4*i +: 4] = d;
            end else if (d == 4'd9) begin
                up_val[4*i +: 4] = 4'd0;
            end else begin
                up_val[4*i +: 4] = d + 4'd1;
            end

            if (!dn_en[i]) begin
                dn_val[4*i +: 4] = d;
            end else if (d == 4'd0) begin
                dn_val[4*i +: 4] = 4'd9;
            end else begin
                dn_val[4*i +: 4] = d - 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Count register: reset > load > up > down > hold.
    // inc=dec=1 leaves both apply_* low and therefore holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            Count <= '0;
        end else if (load) begin
            Count <= load_fix;
        end else if (apply_up) begin
            Count <= up_val;
        end else if (apply_dn) begin
            Count <= dn_val;
        end
    end

endmodule
